grain_ks_engine: RTL and testbench
==================================

# grain_ks_engine

Parametrised successor to the fixed grain keystream core. Holds the same 80-bit LFSR and 24-bit NFSR and the same tap functions, and adds:
- a start/stop control FSM;
- a configurable warm-up (initialisation) phase;
- serial-to-parallel packing of the keystream into OUT_W-bit words;
- a valid/ready output handshake with backpressure that freezes the cipher state.

It sits between the seed/key loader and the encryption XOR datapath.

## Interface
- OUT_W, 8, keystream word width; legal 1..32
- INIT_ROUNDS, 160, warm-up clocks after load; legal ≥1
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: load seed and begin warm-up
- stop  in  1  one-cycle pulse: return to IDLE
- seed  in  104  seed[103:24] loads L[79:0]; seed[23:0] loads N[23:0]
- busy  out  1  state != IDLE
- init_done  out  1  state == RUN
- ks_valid  out  1  ks_data holds an undelivered word
- ks_ready  in  1  consumer accepts the word on this edge
- ks_data  out  OUT_W  keystream word; the first-generated bit is in bit 0

## Operation
- **Shift (one step):**
  - L <= {fL, L[79:1]}; N <= {fN, N[23:1]}.
  - fL = L62^L51^L38^L23^L13^L0.
  - g = N0^N5^N6^N9^N17^N22^(N4&N13)^(N8&N16)^(N5&N11&N14)^(N2&N5&N8&N10).
  - fN = L0^g.
- **Keystream bit** (combinational, from current state):
  - z = L0^L3^(L1&L2)^N2^(N1&L5)^(N3&L7)^(L8&L13&N5).
- **States:** IDLE, INIT, RUN.
  - IDLE: no shifting.
  - start (any state): load L and N from seed; rnd <= 0; cnt <= 0; collector <= 0; ks_valid <= 0; go to INIT.
  - INIT: shift every edge; rnd++. On the edge where rnd == INIT_ROUNDS-1, go to RUN. z is not emitted.
  - RUN: shift on every non-stalled edge; collector[cnt] <= z; cnt++.
    - On a shifting edge with cnt == OUT_W-1: ks_data <= {z, collector[OUT_W-2:0]}; ks_valid <= 1; cnt <= 0.
  - stop: go to IDLE and clear ks_valid. The L and N registers hold their values.
- **Handshake:**
  - A transfer occurs on an edge where ks_valid && ks_ready. ks_valid clears unless a new word loads on the same edge, in which case it stays 1 with the new data.
  - ks_data is stable while ks_valid=1 and ks_ready=0.
- **Stall:** cnt == OUT_W-1 && ks_valid && !ks_ready. While stalled, L, N, cnt and the collector all hold, so no keystream bit is lost or duplicated.
- **Counter widths:**
  - rnd is $clog2(INIT_ROUNDS+1) bits.
  - cnt is $clog2(OUT_W)+1 bits.

## Timing
- **Reset values:** ks_valid=0, ks_data=0, busy=0, init_done=0, L=0, N=0, rnd=0, cnt=0, state=IDLE. Reset applies immediately and asynchronously, including mid-INIT and mid-RUN.
- **Latency:** let the start edge be edge 0.
  - RUN is entered at edge INIT_ROUNDS.
  - The first ks_valid rises at edge INIT_ROUNDS+OUT_W.
  - Default parameters: edge 168.
- **Throughput:** one word per OUT_W clocks while ks_ready=1. With OUT_W=1, one bit per clock and no bubble.
- **Simultaneous start and stop:** start wins.
- **start during RUN while ks_valid=1:** the pending word is discarded and ks_valid=0 on the next cycle.
- **stop or start while stalled:** takes effect on that same edge.

## Configuration
- GRAIN_KS_INIT_FB_EN defined:
  - During INIT, z is XORed into both feedbacks: fL' = fL^z, fN' = fN^z.
  - Gives standard Grain-style key diffusion.
- Undefined:
  - INIT shifts with plain fL and fN; z is discarded.
  - Cycle timing is identical in both builds.

## Test plan
- **All-zero seed**, OUT_W=8, INIT_ROUNDS=160, ks_ready=1 → ks_valid first at edge 168. Every word is 8'h00 in both builds; L and N remain 0.
- **Seed 104'h0123456789ABCDEF0123456789**, ks_ready=1, 64 words, both macro settings → each word matches the bit-accurate reference model; words arrive exactly 8 cycles apart.
- **Backpressure:** ks_ready=0 for 20 cycles after the first ks_valid → ks_data and state are frozen. After release, the concatenated stream equals the unstalled golden stream.
- **OUT_W=1, INIT_ROUNDS=1:** start → ks_valid at edge 2 and every edge after; bit order equals the z sequence.
- **Restart and stop:** start pulsed mid-RUN with ks_valid=1 → ks_valid=0 next cycle and the first new word arrives at edge 168. stop pulsed → busy=0 and init_done=0 next cycle.
- **Reset:** rst low at cycle 50 of INIT → all outputs take their reset values immediately. No ks_valid occurs until a fresh start is given.

Source files
------------

// File: rtl/grain_ks_engine_if.sv
// Control, seed and keystream handshake bundle for grain_ks_engine.
// master: seed loader / consumer side; slave: the engine.
interface grain_ks_engine_if #(
  parameter int unsigned OUT_W = 8
) ();
  logic             start;
  logic             stop;
  logic [103:0]     seed;
  logic             busy;
  logic             init_done;
  logic             ks_valid;
  logic             ks_ready;
  logic [OUT_W-1:0] ks_data;

  modport master (
    output start, stop, seed, ks_ready,
    input  busy, init_done, ks_valid, ks_data
  );

  modport slave (
    input  start, stop, seed, ks_ready,
    output busy, init_done, ks_valid, ks_data
  );
endinterface

// File: rtl/grain_ks_engine.sv
// Grain-style keystream engine: 80-bit LFSR + 24-bit NFSR, warm-up phase, OUT_W-bit word packing
// with valid/ready backpressure. GRAIN_KS_INIT_FB_EN feeds z into both feedbacks during warm-up.
module grain_ks_engine #(
  parameter int unsigned OUT_W       = 8,
  parameter int unsigned INIT_ROUNDS = 160
) (
  input logic              clk,
  input logic              rst,
  grain_ks_engine_if.slave ks
);

  localparam int unsigned RndW = $clog2(INIT_ROUNDS + 1);
  localparam int unsigned CntW = $clog2(OUT_W) + 1;

`ifdef GRAIN_KS_INIT_FB_EN
  localparam bit InitFb = 1'b1;
`else
  localparam bit InitFb = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StInit, StRun} state_e;

  state_e           state_q, state_d;
  logic [79:0]      lfsr_q, lfsr_d;
  logic [23:0]      nfsr_q, nfsr_d;
  logic [RndW-1:0]  rnd_q, rnd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0] coll_q, coll_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  logic f_l, g_n, z, last_bit, stall, init_inj;

  assign f_l = lfsr_q[62] ^ lfsr_q[51] ^ lfsr_q[38] ^ lfsr_q[23] ^ lfsr_q[13] ^ lfsr_q[0];

  assign g_n = nfsr_q[0] ^ nfsr_q[5] ^ nfsr_q[6] ^ nfsr_q[9] ^ nfsr_q[17] ^ nfsr_q[22]
             ^ (nfsr_q[4] & nfsr_q[13]) ^ (nfsr_q[8] & nfsr_q[16])
             ^ (nfsr_q[5] & nfsr_q[11] & nfsr_q[14])
             ^ (nfsr_q[2] & nfsr_q[5] & nfsr_q[8] & nfsr_q[10]);

  assign z = lfsr_q[0] ^ lfsr_q[3] ^ (lfsr_q[1] & lfsr_q[2]) ^ nfsr_q[2]
           ^ (nfsr_q[1] & lfsr_q[5]) ^ (nfsr_q[3] & lfsr_q[7])
           ^ (lfsr_q[8] & lfsr_q[13] & nfsr_q[5]);

  assign init_inj = InitFb & z;
  assign last_bit = (cnt_q == CntW'(OUT_W - 1));
  // A completed word cannot land while the previous one is still unaccepted.
  assign stall    = last_bit && valid_q && !ks.ks_ready;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    nfsr_d  = nfsr_q;
    rnd_d   = rnd_q;
    cnt_d   = cnt_q;
    coll_d  = coll_q;
    data_d  = data_q;
    valid_d = valid_q;

    if (valid_q && ks.ks_ready) begin
      valid_d = 1'b0;
    end

    if (ks.start) begin
      lfsr_d  = ks.seed[103:24];
      nfsr_d  = ks.seed[23:0];
      rnd_d   = '0;
      cnt_d   = '0;
      coll_d  = '0;
      valid_d = 1'b0;
      state_d = StInit;
    end else if (ks.stop) begin
      valid_d = 1'b0;
      state_d = StIdle;
    end else begin
      case (state_q)
        StInit: begin
          lfsr_d = {f_l ^ init_inj, lfsr_q[79:1]};
          nfsr_d = {lfsr_q[0] ^ g_n ^ init_inj, nfsr_q[23:1]};
          rnd_d  = rnd_q + 1'b1;
          if (rnd_q == RndW'(INIT_ROUNDS - 1)) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (!stall) begin
            lfsr_d = {f_l, lfsr_q[79:1]};
            nfsr_d = {lfsr_q[0] ^ g_n, nfsr_q[23:1]};
            for (int unsigned i = 0; i < OUT_W; i++) begin
              if (cnt_q == CntW'(i)) begin
                coll_d[i] = z;
              end
            end
            if (last_bit) begin
              data_d  = coll_d;
              valid_d = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      lfsr_q  <= '0;
      nfsr_q  <= '0;
      rnd_q   <= '0;
      cnt_q   <= '0;
      coll_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      nfsr_q  <= nfsr_d;
      rnd_q   <= rnd_d;
      cnt_q   <= cnt_d;
      coll_q  <= coll_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign ks.busy      = (state_q != StIdle);
  assign ks.init_done = (state_q == StRun);
  assign ks.ks_valid  = valid_q;
  assign ks.ks_data   = data_q;

endmodule

// File: tb/tb_grain_ks_engine.sv
// Self-checking bench for grain_ks_engine: default (8/160) and minimal (1/1) instances compared
// against a bit-level reference of the cipher, with random seeds and random backpressure.
module tb_grain_ks_engine;

`ifdef GRAIN_KS_INIT_FB_EN
  localparam bit FbEn = 1'b1;
`else
  localparam bit FbEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  grain_ks_engine_if #(.OUT_W(8)) bus ();
  grain_ks_engine_if #(.OUT_W(1)) bus1 ();

  grain_ks_engine #(.OUT_W(8), .INIT_ROUNDS(160)) dut (
    .clk (clk),
    .rst (rst),
    .ks  (bus)
  );

  grain_ks_engine #(.OUT_W(1), .INIT_ROUNDS(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .ks  (bus1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: registers as plain bit arrays, index 0 is the output end.
  bit ml[80];
  bit mn[24];
  bit exp_bits[$];

  function automatic bit m_z();
    return ml[0] ^ ml[3] ^ (ml[1] & ml[2]) ^ mn[2] ^ (mn[1] & ml[5]) ^ (mn[3] & ml[7])
         ^ (ml[8] & ml[13] & mn[5]);
  endfunction

  function automatic void m_step(input bit inj);
    bit zz, fl, fn;
    zz = m_z();
    fl = ml[62] ^ ml[51] ^ ml[38] ^ ml[23] ^ ml[13] ^ ml[0];
    fn = ml[0] ^ mn[0] ^ mn[5] ^ mn[6] ^ mn[9] ^ mn[17] ^ mn[22] ^ (mn[4] & mn[13])
       ^ (mn[8] & mn[16]) ^ (mn[5] & mn[11] & mn[14]) ^ (mn[2] & mn[5] & mn[8] & mn[10]);
    if (inj) begin
      fl ^= zz;
      fn ^= zz;
    end
    for (int i = 0; i < 79; i++) ml[i] = ml[i+1];
    ml[79] = fl;
    for (int i = 0; i < 23; i++) mn[i] = mn[i+1];
    mn[23] = fn;
  endfunction

  function automatic void m_gen(input logic [103:0] sd, input int rounds, input int nbits);
    exp_bits.delete();
    for (int i = 0; i < 80; i++) ml[i] = sd[24+i];
    for (int i = 0; i < 24; i++) mn[i] = sd[i];
    repeat (rounds) m_step(FbEn);
    repeat (nbits) begin
      exp_bits.push_back(m_z());
      m_step(1'b0);
    end
  endfunction

  function automatic logic [63:0] exp_word(input int k, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = exp_bits[k*w+i];
    return r;
  endfunction

  function automatic logic [103:0] rand_seed();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[103:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start; returns having sampled just after edge 0.
  task automatic pulse_start(input logic [103:0] sd);
    bus.seed  = sd;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Waits for the first ks_valid after a start, checking RUN entry and first-word edge.
  task automatic wait_first(input string tag);
    int e, run_e;
    e = 0;
    run_e = -1;
    while (!bus.ks_valid && e < 400) begin
      tick();
      e++;
      if (bus.init_done && run_e < 0) run_e = e;
    end
    check({tag, "_run_edge"}, 64'(run_e), 64'd160);
    check({tag, "_first_valid_edge"}, 64'(e), 64'd168);
  endtask

  // Consumes nwords words starting at the currently presented (undelivered) word.
  task automatic stream(input string tag, input int nwords, input bit rnd_rdy, input bit gap_chk);
    int k, cyc, last;
    bit is_new, prev_valid, rdy;
    k = 0;
    cyc = 0;
    last = 0;
    is_new = 1'b1;
    while (k < nwords && cyc < 4000) begin
      if (bus.ks_valid && is_new) begin
        check($sformatf("%s_word%0d", tag, k), 64'(bus.ks_data), exp_word(k, 8));
        if (gap_chk && k > 0) check($sformatf("%s_gap%0d", tag, k), 64'(cyc - last), 64'd8);
        last = cyc;
        k++;
      end
      prev_valid = bus.ks_valid;
      rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.ks_ready = rdy;
      tick();
      cyc++;
      is_new = !prev_valid || rdy;
    end
    check({tag, "_word_count"}, 64'(k), 64'(nwords));
    bus.ks_ready = 1'b1;
  endtask

  task automatic run_seed(input string tag, input logic [103:0] sd, input int nwords);
    m_gen(sd, 160, nwords * 8);
    bus.ks_ready = 1'b1;
    pulse_start(sd);
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    wait_first(tag);
    stream(tag, nwords, 1'b0, 1'b1);
  endtask

  initial begin
    logic [103:0] sd;
    logic [7:0]   held;
    int           nv;

    rst = 1'b0;
    bus.start = 1'b0;  bus.stop = 1'b0;  bus.seed = '0;  bus.ks_ready = 1'b1;
    bus1.start = 1'b0; bus1.stop = 1'b0; bus1.seed = '0; bus1.ks_ready = 1'b1;
    #1;
    check("rst_valid", 64'(bus.ks_valid), 64'd0);
    check("rst_data", 64'(bus.ks_data), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_init_done", 64'(bus.init_done), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    tick();

    run_seed("zero", '0, 8);
    run_seed("fixed", 104'h0123456789ABCDEF0123456789, 64);
    run_seed("rand", rand_seed(), 12);

    // Backpressure: 20 stalled cycles, then random ready; stream must be unbroken.
    sd = rand_seed();
    m_gen(sd, 160, 24 * 8);
    pulse_start(sd);
    wait_first("bp");
    bus.ks_ready = 1'b0;
    held = bus.ks_data;
    repeat (20) begin
      tick();
      check("bp_hold_data", 64'(bus.ks_data), 64'(held));
      check("bp_hold_valid", 64'(bus.ks_valid), 64'd1);
      check("bp_hold_run", 64'(bus.init_done), 64'd1);
    end
    stream("bp", 24, 1'b1, 1'b0);

    // Restart mid-RUN with a pending word, then stop while stalled.
    sd = rand_seed();
    pulse_start(sd);
    wait_first("pre");
    bus.ks_ready = 1'b0;
    repeat (3) tick();
    sd = rand_seed();
    m_gen(sd, 160, 8 * 8);
    pulse_start(sd);
    check("restart_valid_clear", 64'(bus.ks_valid), 64'd0);
    check("restart_init", 64'(bus.init_done), 64'd0);
    bus.ks_ready = 1'b1;
    wait_first("restart");
    stream("restart", 8, 1'b0, 1'b1);
    bus.ks_ready = 1'b0;
    repeat (12) tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("stop_busy", 64'(bus.busy), 64'd0);
    check("stop_init_done", 64'(bus.init_done), 64'd0);
    check("stop_valid", 64'(bus.ks_valid), 64'd0);
    bus.ks_ready = 1'b1;

    // OUT_W=1, INIT_ROUNDS=1: one bit per clock from edge 2 onward.
    sd = rand_seed();
    m_gen(sd, 1, 40);
    bus1.seed  = sd;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    tick();
    check("w1_edge1_valid", 64'(bus1.ks_valid), 64'd0);
    for (int k = 0; k < 40; k++) begin
      tick();
      check($sformatf("w1_valid%0d", k), 64'(bus1.ks_valid), 64'd1);
      check($sformatf("w1_bit%0d", k), 64'(bus1.ks_data), 64'(exp_bits[k]));
    end

    // Asynchronous reset mid-INIT.
    sd = rand_seed();
    pulse_start(sd);
    repeat (50) tick();
    check("init_busy", 64'(bus.busy), 64'd1);
    check("init_not_run", 64'(bus.init_done), 64'd0);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_init_done", 64'(bus.init_done), 64'd0);
    check("arst_valid", 64'(bus.ks_valid), 64'd0);
    check("arst_data", 64'(bus.ks_data), 64'd0);
    check("arst_w1_busy", 64'(bus1.busy), 64'd0);
    check("arst_w1_data", 64'(bus1.ks_data), 64'd0);
    #4 rst = 1'b1;
    nv = 0;
    repeat (300) begin
      tick();
      if (bus.ks_valid || bus1.ks_valid || bus.busy) nv++;
    end
    check("arst_no_activity", 64'(nv), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
